// File: rtl/kalman_frame_rx_if.sv
// kalman_frame_rx_if: signal bundle of the attitude telemetry receiver.
//   rx          serial line into the receiver (idle high)
//   roll/pitch/yaw  last complete frame, signed 16-bit
//   frame_valid 1-cycle pulse when roll/pitch/yaw update
//   byte_valid  1-cycle pulse when byte_data holds a freshly framed byte
//   byte_data   last correctly framed byte
//   framing_err 1-cycle pulse on a low stop bit
//   timeout_err 1-cycle pulse on mid-frame inactivity (timeout build only)
// The master modport is the line driver / frame consumer; the slave modport is the receiver.
interface kalman_frame_rx_if;
    logic               rx;
    logic signed [15:0] roll;
    logic signed [15:0] pitch;
    logic signed [15:0] yaw;
    logic               frame_valid;
    logic               byte_valid;
    logic        [7:0]  byte_data;
    logic               framing_err;
    logic               timeout_err;

    modport master (
        output rx,
        input  roll, pitch, yaw, frame_valid, byte_valid, byte_data, framing_err, timeout_err
    );

    modport slave (
        input  rx,
        output roll, pitch, yaw, frame_valid, byte_valid, byte_data, framing_err, timeout_err
    );
endinterface

// File: rtl/kalman_frame_rx.sv
// kalman_frame_rx: 8N1 UART receiver plus decoder for the 8-byte attitude frame
// DE AD roll_hi roll_lo pitch_hi pitch_lo yaw_hi yaw_lo.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    kalman_frame_rx_if.slave (rx in; roll/pitch/yaw, frame_valid, byte_valid,
//          byte_data, framing_err, timeout_err out)
// Parameters:
//   BAUD_DIV        clk cycles per UART bit (>= 4)
//   TIMEOUT_CYCLES  idle cycles tolerated mid-frame (timeout build only)
// Build option: define FRAME_TIMEOUT_EN to abort a stalled frame after TIMEOUT_CYCLES;
// without it timeout_err is tied low and the parser waits indefinitely.
module kalman_frame_rx #(
    parameter int unsigned BAUD_DIV       = 1041,
    parameter int unsigned TIMEOUT_CYCLES = 20 * BAUD_DIV
) (
    input logic             clk,
    input logic             rst_n,
    kalman_frame_rx_if.slave bus
);

    localparam int unsigned CntW = $clog2(BAUD_DIV);
    localparam logic [CntW-1:0] HalfBit = CntW'(BAUD_DIV / 2 - 1);
    localparam logic [CntW-1:0] FullBit = CntW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {BitIdle, BitStart, BitData, BitStop, BitBreak} bit_state_e;
    typedef enum logic [1:0] {PrsHunt0, PrsHunt1, PrsPayload} prs_state_e;

    // ---------------------------------------------------------------- synchroniser
    logic rx_meta_q, rxs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // ---------------------------------------------------------------- bit FSM
    bit_state_e      bit_state_q, bit_state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_data_q, byte_data_d;
    logic            byte_valid_q, byte_valid_d;
    logic            framing_err_q, framing_err_d;
    logic            cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_state_q <= BitIdle;
        end else begin
            bit_state_q <= bit_state_d;
        end
    end

    always_comb begin
        bit_state_d = bit_state_q;
        unique case (bit_state_q)
            BitIdle:  if (!rxs_q) bit_state_d = BitStart;
            BitStart: if (cnt_zero) bit_state_d = rxs_q ? BitIdle : BitData;
            BitData:  if (cnt_zero && bit_idx_q == 3'd7) bit_state_d = BitStop;
            BitStop:  if (cnt_zero) bit_state_d = rxs_q ? BitIdle : BitBreak;
            BitBreak: if (rxs_q) bit_state_d = BitIdle;
            default:  bit_state_d = BitIdle;
        endcase
    end

    always_comb begin
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        byte_data_d   = byte_data_q;
        byte_valid_d  = 1'b0;
        framing_err_d = 1'b0;
        unique case (bit_state_q)
            // Preload half a bit so the start bit is re-checked at its centre.
            BitIdle: cnt_d = HalfBit;
            BitStart: begin
                if (cnt_zero) begin
                    cnt_d     = FullBit;
                    bit_idx_d = 3'd0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            BitData: begin
                if (cnt_zero) begin
                    shift_d   = {rxs_q, shift_q[7:1]};
                    cnt_d     = FullBit;
                    bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            BitStop: begin
                if (cnt_zero) begin
                    if (rxs_q) begin
                        byte_data_d  = shift_q;
                        byte_valid_d = 1'b1;
                    end else begin
                        framing_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'h00;
            byte_data_q   <= 8'h00;
            byte_valid_q  <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            byte_data_q   <= byte_data_d;
            byte_valid_q  <= byte_valid_d;
            framing_err_q <= framing_err_d;
        end
    end

    // ---------------------------------------------------------------- frame parser
    prs_state_e      prs_state_q, prs_state_d;
    logic [2:0]      idx_q, idx_d;
    logic [4:0][7:0] stage_q, stage_d;
    logic [15:0]     roll_q, roll_d, pitch_q, pitch_d, yaw_q, yaw_d;
    logic            frame_valid_q, frame_valid_d;
    logic            timeout_hit;

`ifdef FRAME_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        timeout_err_q;

    // Restarts on every byte; only runs while a frame is partially assembled.
    always_comb begin
        tmo_cnt_d   = tmo_cnt_q;
        timeout_hit = 1'b0;
        if (byte_valid_q || prs_state_q == PrsHunt0) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TIMEOUT_CYCLES - 1) begin
            timeout_hit = 1'b1;
            tmo_cnt_d   = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_hit;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout_hit           = 1'b0;
    assign bus.timeout_err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prs_state_q <= PrsHunt0;
        end else begin
            prs_state_q <= prs_state_d;
        end
    end

    always_comb begin
        prs_state_d = prs_state_q;
        if (timeout_hit || framing_err_q) begin
            prs_state_d = PrsHunt0;
        end else if (byte_valid_q) begin
            unique case (prs_state_q)
                PrsHunt0: if (byte_data_q == 8'hDE) prs_state_d = PrsHunt1;
                PrsHunt1: begin
                    if (byte_data_q == 8'hAD) begin
                        prs_state_d = PrsPayload;
                    end else if (byte_data_q != 8'hDE) begin
                        prs_state_d = PrsHunt0;
                    end
                end
                PrsPayload: if (idx_q == 3'd5) prs_state_d = PrsHunt0;
                default: prs_state_d = PrsHunt0;
            endcase
        end
    end

    always_comb begin
        idx_d         = idx_q;
        stage_d       = stage_q;
        roll_d        = roll_q;
        pitch_d       = pitch_q;
        yaw_d         = yaw_q;
        frame_valid_d = 1'b0;
        if (byte_valid_q) begin
            unique case (prs_state_q)
                PrsHunt1: if (byte_data_q == 8'hAD) idx_d = 3'd0;
                PrsPayload: begin
                    if (idx_q == 3'd5) begin
                        // Last byte goes straight to yaw so all three update on one edge.
                        roll_d        = {stage_q[0], stage_q[1]};
                        pitch_d       = {stage_q[2], stage_q[3]};
                        yaw_d         = {stage_q[4], byte_data_q};
                        frame_valid_d = 1'b1;
                    end else begin
                        stage_d[idx_q] = byte_data_q;
                        idx_d          = idx_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q         <= 3'd0;
            stage_q       <= '0;
            roll_q        <= 16'h0000;
            pitch_q       <= 16'h0000;
            yaw_q         <= 16'h0000;
            frame_valid_q <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            stage_q       <= stage_d;
            roll_q        <= roll_d;
            pitch_q       <= pitch_d;
            yaw_q         <= yaw_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign bus.roll        = roll_q;
    assign bus.pitch       = pitch_q;
    assign bus.yaw         = yaw_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.byte_valid  = byte_valid_q;
    assign bus.byte_data   = byte_data_q;
    assign bus.framing_err = framing_err_q;

endmodule
